// File: rtl/nmul_pkg.sv
// ============================================================================
// Module      : nmul_pkg
// Description : Shared helpers for the pipelined multiplier: product width and
//               pipeline latency (latency follows NMUL_INPUT_REG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nmul_pkg;

    function automatic int prod_width(input int n);
        return 2 * n;
    endfunction

    function automatic int latency(input int n);
`ifdef NMUL_INPUT_REG_EN
        return n + 1;
`else
        return n;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/nmul_stage.sv
// ============================================================================
// Module      : nmul_stage
// Description : One multiplier pipeline stage: adds A masked by B[S], shifted
//               by S, to the incoming partial sum and forwards the operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmul_stage
    import nmul_pkg::*;
#(
    parameter int Nsize = 4,
    parameter int S     = 0
) (
    input  logic                           Clk,
    input  logic                           Clr,
    input  logic [prod_width(Nsize)-1:0]   psum_i,
    input  logic [Nsize-1:0]               a_i,
    input  logic [Nsize-1:0]               b_i,
    output logic [prod_width(Nsize)-1:0]   psum_o,
    output logic [Nsize-1:0]               a_o,
    output logic [Nsize-1:0]               b_o
);

    localparam int PW = prod_width(Nsize);

    logic [PW-1:0]    pp_w;
    logic [PW-1:0]    psum_d;
    logic [PW-1:0]    psum_q;
    logic [Nsize-1:0] a_q;
    logic [Nsize-1:0] b_q;

    // Zero-extend before shifting so the high bits of A are not lost.
    assign pp_w   = PW'(a_i & {Nsize{b_i[S]}}) << S;
    assign psum_d = psum_i + pp_w;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            psum_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            psum_q <= psum_d;
            a_q    <= a_i;
            b_q    <= b_i;
        end
    end

    assign psum_o = psum_q;
    assign a_o    = a_q;
    assign b_o    = b_q;

endmodule

`default_nettype wire

// File: rtl/n_mul.sv
// ============================================================================
// Module      : n_mul
// Description : Pipelined unsigned Nsize x Nsize multiplier, one partial product
//               per stage. Define NMUL_INPUT_REG_EN to add an input register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n_mul
    import nmul_pkg::*;
#(
    parameter int Nsize = 4
) (
    input  logic                           Clk,
    input  logic                           Clr,
    input  logic [Nsize-1:0]               A,
    input  logic [Nsize-1:0]               B,
    output logic [prod_width(Nsize)-1:0]   R
);

    localparam int PW = prod_width(Nsize);

    logic [Nsize-1:0] a_s;
    logic [Nsize-1:0] b_s;

`ifdef NMUL_INPUT_REG_EN
    logic [Nsize-1:0] a_in_q;
    logic [Nsize-1:0] b_in_q;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            a_in_q <= '0;
            b_in_q <= '0;
        end else begin
            a_in_q <= A;
            b_in_q <= B;
        end
    end

    assign a_s = a_in_q;
    assign b_s = b_in_q;
`else
    assign a_s = A;
    assign b_s = B;
`endif

    // Element s feeds stage s; the final element carries the product.
    logic [PW-1:0]    psum_c [0:Nsize];
    logic [Nsize-1:0] a_c    [0:Nsize];
    logic [Nsize-1:0] b_c    [0:Nsize];

    assign psum_c[0] = '0;
    assign a_c[0]    = a_s;
    assign b_c[0]    = b_s;

    for (genvar s = 0; s < Nsize; s++) begin : g_stage
        nmul_stage #(
            .Nsize (Nsize),
            .S     (s)
        ) u_stage (
            .Clk    (Clk),
            .Clr    (Clr),
            .psum_i (psum_c[s]),
            .a_i    (a_c[s]),
            .b_i    (b_c[s]),
            .psum_o (psum_c[s+1]),
            .a_o    (a_c[s+1]),
            .b_o    (b_c[s+1])
        );
    end

    assign R = psum_c[Nsize];

endmodule

`default_nettype wire

// File: tb/tb_n_mul.sv
// ============================================================================
// Module      : tb_n_mul
// Description : Self-checking bench for n_mul at Nsize = 2, 8 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n_mul;

    localparam int L2 = nmul_pkg::latency(2);
    localparam int L8 = nmul_pkg::latency(8);
    localparam int L1 = nmul_pkg::latency(1);
    localparam int W2 = nmul_pkg::prod_width(2);
    localparam int W8 = nmul_pkg::prod_width(8);
    localparam int W1 = nmul_pkg::prod_width(1);

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [1:0]    a2 = '0, b2 = '0;
    logic [7:0]    a8 = '0, b8 = '0;
    logic [0:0]    a1 = '0, b1 = '0;
    logic [W2-1:0] r2;
    logic [W8-1:0] r8;
    logic [W1-1:0] r1;

    int checks = 0;
    int errors = 0;

    // Expected products, in order of acceptance, not yet visible on R.
    int q2[$];
    int q8[$];
    int q1[$];

    always #5 clk = ~clk;

    n_mul #(.Nsize(2)) u_dut2 (.Clk(clk), .Clr(clr), .A(a2), .B(b2), .R(r2));
    n_mul #(.Nsize(8)) u_dut8 (.Clk(clk), .Clr(clr), .A(a8), .B(b8), .R(r8));
    n_mul #(.Nsize(1)) u_dut1 (.Clk(clk), .Clr(clr), .A(a1), .B(b1), .R(r1));

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        int         exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_models();
        q2.delete(); q8.delete(); q1.delete();
        repeat (L2 - 1) q2.push_back(0);
        repeat (L8 - 1) q8.push_back(0);
        repeat (L1 - 1) q1.push_back(0);
    endtask

    // Drive one operand set on every DUT, clock once, check all outputs.
    task automatic tick(input logic [1:0] xa2, input logic [1:0] xb2,
                        input logic [7:0] xa8, input logic [7:0] xb8,
                        input logic xa1, input logic xb1);
        int e2, e8, e1;
        a2 = xa2; b2 = xb2; a8 = xa8; b8 = xb8; a1 = xa1; b1 = xb1;
        @(posedge clk);
        if (clr) begin
            reset_models();
            e2 = 0; e8 = 0; e1 = 0;
        end else begin
            q2.push_back(int'(xa2) * int'(xb2));
            q8.push_back(int'(xa8) * int'(xb8));
            q1.push_back(int'(xa1) * int'(xb1));
            e2 = q2.pop_front();
            e8 = q8.pop_front();
            e1 = q1.pop_front();
        end
        #1;
        chk("model_n2", 64'(r2), 64'(e2));
        chk("model_n8", 64'(r8), 64'(e8));
        chk("model_n1", 64'(r1), 64'(e1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        n = 0;
        for (int a = 1; a <= 3; a++)
            for (int b = 1; b <= 3; b++) begin
                tbl[n].a = 2'(a); tbl[n].b = 2'(b); tbl[n].exp = a * b;
                n++;
            end
        tbl[9]  = '{a: 2'd0, b: 2'd3, exp: 0};
        tbl[10] = '{a: 2'd3, b: 2'd0, exp: 0};

        reset_models();
        #1;
        chk("reset_r2", 64'(r2), 64'd0);
        chk("reset_r8", 64'(r8), 64'd0);
        chk("reset_r1", 64'(r1), 64'd0);

        // Inputs are ignored while Clr is held.
        for (int i = 0; i < 5; i++)
            tick((i % 2) ? 2'd3 : 2'd1, 2'd3, 8'd255, 8'd255, 1'b1, 1'b1);
        @(negedge clk);
        clr = 1'b0;

        // Exhaustive 1..3 pairs then zero operands, back to back.
        for (int i = 0; i < 11 + L2 - 1; i++) begin
            if (i < 11) tick(tbl[i].a, tbl[i].b, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            else        tick(2'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
            if (i >= L2 - 1) chk("table", 64'(r2), 64'(tbl[i - (L2 - 1)].exp));
        end

        // Wide and single-bit corners.
        for (int k = 0; k <= L8; k++) begin
            if (k == 0)      tick(2'd0, 2'd0, 8'd255, 8'd255, 1'b1, 1'b1);
            else if (k == 1) tick(2'd0, 2'd0, 8'd200, 8'd3, 1'b1, 1'b0);
            else             tick(2'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
            if (k == L8 - 1) chk("wide_255x255", 64'(r8), 64'd65025);
            if (k == L8)     chk("wide_200x3", 64'(r8), 64'd600);
            if (k == L1 - 1) chk("n1_1x1", 64'(r1), 64'd1);
            if (k == L1)     chk("n1_1x0", 64'(r1), 64'd0);
        end

        // Clr between edges clears a visible product without a clock.
        for (int i = 0; i < L2; i++) tick(2'd3, 2'd3, 8'd17, 8'd9, 1'b1, 1'b1);
        chk("pre_async_r2", 64'(r2), 64'd9);
        clr = 1'b1;
        #1;
        chk("async_r2", 64'(r2), 64'd0);
        chk("async_r8", 64'(r8), 64'd0);
        chk("async_r1", 64'(r1), 64'd0);
        reset_models();
        @(negedge clk);
        clr = 1'b0;

        // Mid-operation pulse spanning one edge discards 3x3 and 2x3.
        tick(2'd3, 2'd3, 8'd0, 8'd0, 1'b0, 1'b0);
        a2 = 2'd2; b2 = 2'd3;
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("midop_r2_clr", 64'(r2), 64'd0);
        @(posedge clk);
        #1;
        chk("midop_r2_edge", 64'(r2), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        reset_models();
        for (int i = 0; i < L2 + 2; i++) begin
            tick(2'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
            chk("midop_no_9_6", 64'((r2 == 4'd9) || (r2 == 4'd6)), 64'd0);
        end

        // Random streams against the delay-line reference.
        for (int i = 0; i < 200; i++)
            tick(2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
